// File: rtl/hpm_counter_bank_pkg.sv
// Shared types and constants for the hardware performance counter bank.
package hpm_counter_bank_pkg;

    // CSR register group addressed by a write/read strobe.
    typedef enum logic [2:0] {
        CNT_LO  = 3'd0,
        CNT_HI  = 3'd1,
        EVT_SEL = 3'd2,
        INHIBIT = 3'd3,
        OVF     = 3'd4
    } hpm_csr_target_t;

    // Event number 0 never counts.
    localparam logic [4:0] HPM_EVENT_NONE = 5'd0;

    // Build-time configuration of the counter bank as carried in the CPU config.
    typedef struct packed {
        logic       include_hpm;
        logic [4:0] num_counters;
        logic [6:0] counter_w;
        logic [5:0] num_events;
        logic       writeable;
        logic       include_overflow_irq;
    } hpm_config_t;

    localparam hpm_config_t HPM_DEFAULT_CONFIG = '{
        include_hpm:          1'b1,
        num_counters:         5'd4,
        counter_w:            7'd48,
        num_events:           6'd16,
        writeable:            1'b1,
        include_overflow_irq: 1'b1
    };

    // Read-back layout of an event-select register.
    function automatic logic [31:0] evt_sel_word(input logic ovf_en, input logic [4:0] sel);
        return {ovf_en, 26'd0, sel};
    endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// One performance counter: event select, stage-2 add, write port, sticky overflow.
module hpm_counter
    import hpm_counter_bank_pkg::*;
#(
    parameter int COUNTER_W  = 48,
    parameter int NUM_EVENTS = 16,
    parameter int WRITEABLE  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*NUM_EVENTS-1:0] inc_vec,
    input  logic                    inhibit,
    input  logic                    wr_lo,
    input  logic                    wr_hi,
    input  logic                    wr_evt,
    input  logic [31:0]             wdata,
    input  logic                    ovf_clr,
    output logic [COUNTER_W-1:0]    count,
    output logic [4:0]              evt_sel,
    output logic                    ovf_en,
    output logic                    ovf
);
    localparam int   HI_W   = COUNTER_W - 32;
    localparam logic WR_ENA = (WRITEABLE != 0);

    logic [COUNTER_W-1:0] count_q, count_d;
    logic [4:0]           evt_sel_q, evt_sel_d;
    logic                 ovf_en_q, ovf_en_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           inc_s;
    logic [COUNTER_W:0]   sum_s;
    logic                 carry_s;

    // Pick the registered increment of the selected event; none for event 0, unknown events or inhibit.
    always_comb begin
        inc_s = 2'd0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            inc_s = inc_s | (((evt_sel_q == 5'(e)) && (evt_sel_q != HPM_EVENT_NONE) && !inhibit)
                             ? inc_vec[2*e +: 2] : 2'd0);
        end
        sum_s = {1'b0, count_q} + {{(COUNTER_W-1){1'b0}}, inc_s};
    end

    // Next state: a counter write beats and drops this cycle's increment; overflow set beats clear.
    always_comb begin
        count_d   = count_q;
        evt_sel_d = evt_sel_q;
        ovf_en_d  = ovf_en_q;
        carry_s   = 1'b0;
        if (wr_lo && WR_ENA) begin
            count_d[31:0] = wdata;
        end else if (wr_hi && WR_ENA) begin
            count_d[COUNTER_W-1:32] = wdata[HI_W-1:0];
        end else begin
            count_d = sum_s[COUNTER_W-1:0];
            carry_s = sum_s[COUNTER_W];
        end
        if (wr_evt) begin
            evt_sel_d = wdata[4:0];
            ovf_en_d  = wdata[31];
        end else begin
            evt_sel_d = evt_sel_q;
            ovf_en_d  = ovf_en_q;
        end
        ovf_d = (ovf_q & ~ovf_clr) | carry_s;
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            evt_sel_q <= 5'd0;
            ovf_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            evt_sel_q <= evt_sel_d;
            ovf_en_q  <= ovf_en_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count   = count_q;
    assign evt_sel = evt_sel_q;
    assign ovf_en  = ovf_en_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of machine performance counters with CSR access and overflow interrupt.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int NUM_COUNTERS         = 4,
    parameter int COUNTER_W            = 48,
    parameter int NUM_EVENTS           = 16,
    parameter int WRITEABLE            = 1,
    parameter int INCLUDE_OVERFLOW_IRQ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*NUM_EVENTS-1:0] event_inc,
    input  logic                    csr_wr,
    input  logic [2:0]              csr_target,
    input  logic [4:0]              csr_idx,
    input  logic [31:0]             csr_wdata,
    input  logic                    csr_rd,
    output logic [31:0]             csr_rdata,
    output logic                    csr_rdata_valid,
    output logic                    ovf_irq
);
    localparam logic [5:0] NUM_CNT = 6'(NUM_COUNTERS);

    hpm_csr_target_t         tgt_s;
    logic                    idx_ok_s;
    logic [2*NUM_EVENTS-1:0] inc_q, inc_d;
    logic [NUM_COUNTERS-1:0] inhibit_q, inhibit_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    valid_q, valid_d;
    logic                    irq_q, irq_d;

    logic [COUNTER_W-1:0]    cnt_s [NUM_COUNTERS];
    logic [4:0]              sel_s [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] en_s, ovf_s;
    logic [NUM_COUNTERS-1:0] wr_lo_s, wr_hi_s, wr_evt_s, ovf_clr_s;
    logic [COUNTER_W-1:0]    rd_cnt_s;
    logic [4:0]              rd_sel_s;
    logic                    rd_en_s;

    assign tgt_s    = hpm_csr_target_t'(csr_target);
    assign idx_ok_s = ({1'b0, csr_idx} < NUM_CNT);

    // Per-counter write decode and read-side selection of the addressed counter.
    always_comb begin
        wr_lo_s   = '0;
        wr_hi_s   = '0;
        wr_evt_s  = '0;
        ovf_clr_s = (csr_wr && (tgt_s == OVF)) ? csr_wdata[NUM_COUNTERS-1:0] : '0;
        rd_cnt_s  = '0;
        rd_sel_s  = 5'd0;
        rd_en_s   = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            wr_lo_s[i]  = csr_wr && idx_ok_s && (csr_idx == 5'(i)) && (tgt_s == CNT_LO);
            wr_hi_s[i]  = csr_wr && idx_ok_s && (csr_idx == 5'(i)) && (tgt_s == CNT_HI);
            wr_evt_s[i] = csr_wr && idx_ok_s && (csr_idx == 5'(i)) && (tgt_s == EVT_SEL);
            rd_cnt_s    = rd_cnt_s | ((idx_ok_s && (csr_idx == 5'(i))) ? cnt_s[i] : '0);
            rd_sel_s    = rd_sel_s | ((idx_ok_s && (csr_idx == 5'(i))) ? sel_s[i] : 5'd0);
            rd_en_s     = rd_en_s  | (idx_ok_s && (csr_idx == 5'(i)) && en_s[i]);
        end
    end

    // Next values for stage-1 events, inhibit mask, read data and interrupt.
    always_comb begin
        inc_d     = event_inc;
        inhibit_d = (csr_wr && (tgt_s == INHIBIT)) ? csr_wdata[NUM_COUNTERS-1:0] : inhibit_q;
        valid_d   = csr_rd;
        rdata_d   = 32'd0;
        if (csr_rd) begin
            case (tgt_s)
                CNT_LO:  rdata_d = idx_ok_s ? rd_cnt_s[31:0] : 32'd0;
                CNT_HI:  rdata_d = idx_ok_s ? 32'(rd_cnt_s >> 32) : 32'd0;
                EVT_SEL: rdata_d = idx_ok_s ? evt_sel_word(rd_en_s, rd_sel_s) : 32'd0;
                INHIBIT: rdata_d = 32'(inhibit_q);
                OVF:     rdata_d = 32'(ovf_s);
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
        irq_d = (INCLUDE_OVERFLOW_IRQ != 0) ? (|(ovf_s & en_s)) : 1'b0;
    end

    // Bank-level registers: event stage 1, inhibit mask and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q     <= '0;
            inhibit_q <= '1;
            rdata_q   <= 32'd0;
            valid_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inc_q     <= inc_d;
            inhibit_q <= inhibit_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            irq_q     <= irq_d;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        hpm_counter #(
            .COUNTER_W  (COUNTER_W),
            .NUM_EVENTS (NUM_EVENTS),
            .WRITEABLE  (WRITEABLE)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_vec (inc_q),
            .inhibit (inhibit_q[i]),
            .wr_lo   (wr_lo_s[i]),
            .wr_hi   (wr_hi_s[i]),
            .wr_evt  (wr_evt_s[i]),
            .wdata   (csr_wdata),
            .ovf_clr (ovf_clr_s[i]),
            .count   (cnt_s[i]),
            .evt_sel (sel_s[i]),
            .ovf_en  (en_s[i]),
            .ovf     (ovf_s[i])
        );
    end

    assign csr_rdata       = rdata_q;
    assign csr_rdata_valid = valid_q;
    assign ovf_irq         = irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised self-checking bench for hpm_counter_bank against a behavioural model.
module tb_hpm_counter_bank;
    localparam int N  = 4;
    localparam int W  = 48;
    localparam int NE = 16;
    localparam longint unsigned MOD  = 64'd1 << W;
    localparam longint unsigned LO32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] event_inc = 32'd0;
    logic        csr_wr = 1'b0;
    logic [2:0]  csr_target = 3'd0;
    logic [4:0]  csr_idx = 5'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_rd = 1'b0;
    logic [31:0] csr_rdata, nw_rdata;
    logic        csr_rdata_valid, nw_valid;
    logic        ovf_irq, nw_irq;

    int total = 0;
    int bad = 0;

    // Behavioural model state.
    longint unsigned m_cnt [N];
    logic [4:0]      m_sel [N];
    bit              m_en  [N];
    bit              m_ovf [N];
    logic [N-1:0]    m_inh;
    int              m_pend [32];
    logic [31:0]     exp_rdata;
    logic            exp_valid;
    logic            exp_irq;

    always #5 clk = ~clk;

    hpm_counter_bank #(.NUM_COUNTERS(N), .COUNTER_W(W), .NUM_EVENTS(NE),
                       .WRITEABLE(1), .INCLUDE_OVERFLOW_IRQ(1)) dut (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .csr_wr(csr_wr),
        .csr_target(csr_target), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
        .csr_rd(csr_rd), .csr_rdata(csr_rdata), .csr_rdata_valid(csr_rdata_valid),
        .ovf_irq(ovf_irq));

    hpm_counter_bank #(.NUM_COUNTERS(N), .COUNTER_W(W), .NUM_EVENTS(NE),
                       .WRITEABLE(0), .INCLUDE_OVERFLOW_IRQ(1)) dut_nw (
        .clk(clk), .rst_n(rst_n), .event_inc(event_inc), .csr_wr(csr_wr),
        .csr_target(csr_target), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
        .csr_rd(csr_rd), .csr_rdata(nw_rdata), .csr_rdata_valid(nw_valid),
        .ovf_irq(nw_irq));

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 64'd0; m_sel[i] = 5'd0; m_en[i] = 1'b0; m_ovf[i] = 1'b0;
        end
        for (int e = 0; e < 32; e++) m_pend[e] = 0;
        m_inh = '1;
    endtask

    function automatic logic [31:0] model_read(input int t, input int ix);
        logic [31:0] v;
        v = 32'd0;
        if (t == 3) v = 32'(m_inh);
        else if (t == 4) begin
            for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        end else if (ix < N) begin
            if (t == 0)      v = 32'(m_cnt[ix] % LO32);
            else if (t == 1) v = 32'(m_cnt[ix] / LO32);
            else if (t == 2) v = {m_en[ix], 26'd0, m_sel[ix]};
        end
        return v;
    endfunction

    // Advance one clock: predict outputs from the pre-edge state, update the model, then clock the DUT.
    task automatic clock_cycle();
        int t, ix, inc;
        longint unsigned sum;
        t  = int'(csr_target);
        ix = int'(csr_idx);
        exp_valid = csr_rd;
        exp_rdata = csr_rd ? model_read(t, ix) : 32'd0;
        exp_irq = 1'b0;
        for (int i = 0; i < N; i++) if (m_ovf[i] && m_en[i]) exp_irq = 1'b1;
        for (int i = 0; i < N; i++) begin
            inc = (m_sel[i] != 5'd0 && int'(m_sel[i]) < NE && !m_inh[i]) ? m_pend[m_sel[i]] : 0;
            if (csr_wr && t == 4 && csr_wdata[i]) m_ovf[i] = 1'b0;
            if (csr_wr && ix == i && t == 0)
                m_cnt[i] = (m_cnt[i] / LO32) * LO32 + 64'(csr_wdata);
            else if (csr_wr && ix == i && t == 1)
                m_cnt[i] = (64'(csr_wdata) % (MOD / LO32)) * LO32 + (m_cnt[i] % LO32);
            else begin
                sum = m_cnt[i] + 64'(inc);
                if (sum >= MOD) begin
                    m_ovf[i] = 1'b1;
                    sum = sum - MOD;
                end
                m_cnt[i] = sum;
            end
            if (csr_wr && ix == i && t == 2) begin
                m_sel[i] = csr_wdata[4:0];
                m_en[i]  = csr_wdata[31];
            end
        end
        if (csr_wr && t == 3) m_inh = csr_wdata[N-1:0];
        for (int e = 0; e < NE; e++) m_pend[e] = int'(event_inc[2*e +: 2]);
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] t, input logic [4:0] idx, input logic [31:0] d);
        csr_wr = 1'b1; csr_rd = 1'b0; csr_target = t; csr_idx = idx; csr_wdata = d;
        clock_cycle();
        csr_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; event_inc = 32'd0; csr_wr = 1'b0; csr_rd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", csr_rdata); end
        total++; if (csr_rdata_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", csr_rdata_valid); end
        total++; if (ovf_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", ovf_irq); end
        rst_n = 1'b1;
        csr_rd = 1'b1; csr_target = 3'd3; csr_idx = 5'd0;
        clock_cycle();
        total++; if (csr_rdata !== 32'hF || csr_rdata_valid !== 1'b1) begin
            bad++; $display("FAIL reset_inhibit: got v=%b d=%h want v=1 d=0000000f", csr_rdata_valid, csr_rdata); end
        csr_rd = 1'b0;
        csr_write(3'd3, 5'd0, 32'd0);
        for (int k = 0; k < 100; k++) begin
            event_inc = $urandom;
            csr_rd = 1'b1; csr_target = 3'(k % 2); csr_idx = 5'(k % N);
            clock_cycle();
            total++; if (csr_rdata !== 32'd0 || csr_rdata !== exp_rdata || csr_rdata_valid !== 1'b1) begin
                bad++; $display("FAIL sel0_idle: got v=%b d=%h want v=1 d=0", csr_rdata_valid, csr_rdata); end
        end
        event_inc = 32'd0; csr_rd = 1'b0;
    endtask

    task automatic test_count();
        logic [31:0] ev;
        csr_write(3'd2, 5'd1, 32'd2);
        csr_write(3'd3, 5'd0, 32'd0);
        for (int k = 0; k < 14; k++) begin
            ev = $urandom;
            ev[5:4] = 2'd2;
            event_inc = (k < 10) ? ev : 32'd0;
            csr_rd = 1'b1; csr_target = 3'd0; csr_idx = 5'd1;
            clock_cycle();
            total++; if (csr_rdata !== exp_rdata || ovf_irq !== exp_irq) begin
                bad++; $display("FAIL count_model: got d=%h irq=%b want d=%h irq=%b", csr_rdata, ovf_irq, exp_rdata, exp_irq); end
            if (k == 1) begin
                total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL count_latency0: got %h want 0", csr_rdata); end
            end
            if (k == 2) begin
                total++; if (csr_rdata !== 32'd2) begin bad++; $display("FAIL count_first: got %h want 2", csr_rdata); end
            end
            if (k == 13) begin
                total++; if (csr_rdata !== 32'd20) begin bad++; $display("FAIL count_total: got %h want 20", csr_rdata); end
            end
        end
        csr_rd = 1'b0;
    endtask

    task automatic test_overflow();
        event_inc = 32'd0;
        csr_write(3'd1, 5'd0, 32'h0000_FFFF);
        csr_write(3'd0, 5'd0, 32'hFFFF_FFFE);
        csr_write(3'd2, 5'd0, 32'h8000_0003);
        for (int k = 0; k < 5; k++) begin
            event_inc = (k == 0) ? 32'h0000_00C0 : 32'd0;
            csr_rd = 1'b1; csr_target = (k < 3) ? 3'd0 : 3'd4; csr_idx = 5'd0;
            clock_cycle();
            total++; if (csr_rdata !== exp_rdata || ovf_irq !== exp_irq) begin
                bad++; $display("FAIL ovf_model: got d=%h irq=%b want d=%h irq=%b", csr_rdata, ovf_irq, exp_rdata, exp_irq); end
            if (k == 1) begin
                total++; if (ovf_irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_early: got %b want 0", ovf_irq); end
            end
            if (k == 2) begin
                total++; if (csr_rdata !== 32'd1 || ovf_irq !== 1'b1) begin
                    bad++; $display("FAIL ovf_wrap: got d=%h irq=%b want d=1 irq=1", csr_rdata, ovf_irq); end
            end
            if (k == 3) begin
                total++; if (csr_rdata !== 32'd1) begin bad++; $display("FAIL ovf_flag: got %h want 1", csr_rdata); end
            end
        end
        csr_write(3'd4, 5'd0, 32'd1);
        csr_rd = 1'b1; csr_target = 3'd4;
        clock_cycle();
        total++; if (csr_rdata !== 32'd0 || ovf_irq !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: got d=%h irq=%b want d=0 irq=0", csr_rdata, ovf_irq); end
        csr_rd = 1'b0;
    endtask

    task automatic test_collision();
        csr_write(3'd2, 5'd2, 32'd1);
        for (int k = 0; k < 4; k++) begin
            event_inc = (k < 2) ? 32'h0000_0004 : 32'd0;
            csr_wr = (k == 1); csr_target = 3'd0; csr_idx = 5'd2; csr_wdata = 32'h100;
            csr_rd = (k >= 2);
            clock_cycle();
            csr_wr = 1'b0;
            if (k == 2) begin
                total++; if (csr_rdata !== 32'h100 || csr_rdata !== exp_rdata) begin
                    bad++; $display("FAIL collision_write: got %h want 00000100", csr_rdata); end
            end
            if (k == 3) begin
                total++; if (csr_rdata !== 32'h101 || csr_rdata !== exp_rdata) begin
                    bad++; $display("FAIL collision_next: got %h want 00000101", csr_rdata); end
            end
        end
        csr_rd = 1'b0;
    endtask

    task automatic test_rw_same();
        event_inc = 32'd0;
        csr_write(3'd2, 5'd0, 32'd0);
        csr_write(3'd0, 5'd0, 32'd5);
        csr_write(3'd1, 5'd0, 32'd0);
        csr_wr = 1'b1; csr_rd = 1'b1; csr_target = 3'd0; csr_idx = 5'd0; csr_wdata = 32'd9;
        clock_cycle();
        csr_wr = 1'b0;
        total++; if (csr_rdata !== 32'd5 || csr_rdata !== exp_rdata) begin
            bad++; $display("FAIL rw_old: got %h want 5", csr_rdata); end
        clock_cycle();
        total++; if (csr_rdata !== 32'd9 || csr_rdata !== exp_rdata) begin
            bad++; $display("FAIL rw_new: got %h want 9", csr_rdata); end
        csr_rd = 1'b0;
    endtask

    task automatic test_out_of_range();
        event_inc = 32'd0;
        csr_write(3'd0, 5'd7, 32'h0000_DEAD);
        csr_write(3'd2, 5'd7, 32'h8000_0001);
        csr_write(3'd1, 5'd4, 32'h0000_FFFF);
        for (int k = 0; k < 8; k++) begin
            csr_rd = 1'b1;
            csr_target = (k < 4) ? 3'(k % 3) : 3'd0;
            csr_idx = (k < 4) ? ((k == 3) ? 5'd4 : 5'd7) : 5'(k - 4);
            clock_cycle();
            total++; if (csr_rdata !== exp_rdata || csr_rdata_valid !== 1'b1) begin
                bad++; $display("FAIL oor_read_%0d: got %h want %h", k, csr_rdata, exp_rdata); end
            if (k < 4) begin
                total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL oor_zero_%0d: got %h want 0", k, csr_rdata); end
            end
        end
        csr_rd = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            event_inc  = $urandom;
            csr_wr     = ($urandom_range(0, 7) == 0);
            csr_target = 3'($urandom_range(0, 4));
            csr_idx    = 5'($urandom_range(0, 5));
            csr_wdata  = $urandom;
            if (csr_target == 3'd1 && $urandom_range(0, 1) == 1) csr_wdata = 32'h0000_FFFF;
            if (csr_target == 3'd0 && $urandom_range(0, 1) == 1) csr_wdata = 32'hFFFF_FFF0;
            if (csr_target == 3'd2) csr_wdata[4:0] = 5'($urandom_range(0, 17));
            csr_rd     = ($urandom_range(0, 1) == 1);
            clock_cycle();
            total++; if (csr_rdata_valid !== exp_valid || (exp_valid && csr_rdata !== exp_rdata) || ovf_irq !== exp_irq) begin
                bad++; $display("FAIL random_%0d: got v=%b d=%h irq=%b want v=%b d=%h irq=%b",
                                k, csr_rdata_valid, csr_rdata, ovf_irq, exp_valid, exp_rdata, exp_irq); end
        end
        csr_wr = 1'b0; csr_rd = 1'b0; event_inc = 32'd0;
    endtask

    task automatic test_reset_mid();
        event_inc = 32'hFFFF_FFFF;
        csr_rd = 1'b1; csr_target = 3'd0;
        clock_cycle();
        #3 rst_n = 1'b0;
        #1;
        total++; if (csr_rdata !== 32'd0 || csr_rdata_valid !== 1'b0 || ovf_irq !== 1'b0) begin
            bad++; $display("FAIL midreset_out: got d=%h v=%b irq=%b want all 0", csr_rdata, csr_rdata_valid, ovf_irq); end
        event_inc = 32'd0; csr_rd = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            csr_rd = 1'b1; csr_target = 3'(k % 2); csr_idx = 5'(k / 2);
            clock_cycle();
            total++; if (csr_rdata !== 32'd0 || csr_rdata !== exp_rdata) begin
                bad++; $display("FAIL midreset_cnt_%0d: got %h want 0", k, csr_rdata); end
        end
        csr_rd = 1'b0;
    endtask

    task automatic test_writeable();
        csr_write(3'd0, 5'd2, 32'h0000_1234);
        csr_write(3'd2, 5'd2, 32'h8000_0005);
        csr_rd = 1'b1; csr_target = 3'd0; csr_idx = 5'd2;
        clock_cycle();
        total++; if (nw_rdata !== 32'd0 || nw_valid !== 1'b1) begin
            bad++; $display("FAIL nowrite_cnt: got v=%b d=%h want v=1 d=0", nw_valid, nw_rdata); end
        total++; if (csr_rdata !== 32'h1234 || csr_rdata !== exp_rdata) begin
            bad++; $display("FAIL write_cnt: got %h want 00001234", csr_rdata); end
        csr_target = 3'd2;
        clock_cycle();
        total++; if (nw_rdata !== 32'h8000_0005) begin
            bad++; $display("FAIL nowrite_evtsel: got %h want 80000005", nw_rdata); end
        csr_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_collision();
        test_rw_same();
        test_out_of_range();
        test_random();
        test_reset_mid();
        test_writeable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
